// File: rtl/mtm_alu_serializer_pkg.sv
// Shared definitions for the MTM ALU serial link: frame constants, FSM state
// encoding, error-flag bit positions, CRC3 polynomial and a parity helper.
package mtm_alu_pkg;

    localparam int PKT_BITS  = 11;
    localparam int DATA_PKTS = 4;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic TYPE_DATA = 1'b0;
    localparam logic TYPE_CTL  = 1'b1;

    // err_flags = {ERR_DATA, ERR_CRC, ERR_OP, ERR_DATA, ERR_CRC, ERR_OP}
    localparam int ERR_DATA_HI = 5;
    localparam int ERR_CRC_HI  = 4;
    localparam int ERR_OP_HI   = 3;
    localparam int ERR_DATA_LO = 2;
    localparam int ERR_CRC_LO  = 1;
    localparam int ERR_OP_LO   = 0;

    // x^3 + x + 1, leading term implicit
    localparam logic [2:0] CRC3_POLY = 3'b011;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // XOR of all bits: the even-parity bit that makes the total even
    function automatic logic parity7(input logic [6:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Handshake/data bundle between the ALU core (master) and the serializer (slave).
interface mtm_alu_serializer_if;
    logic        start;
    logic [31:0] C;
    logic [3:0]  flags;
    logic        err;
    logic [5:0]  err_flags;
    logic        sout;
    logic        busy;

    modport master (output start, C, flags, err, err_flags, input sout, busy);
    modport slave  (input start, C, flags, err, err_flags, output sout, busy);
endinterface

// File: rtl/mtm_alu_serializer_crc3.sv
// Combinational CRC3 (x^3+x+1, init 0, no final XOR) over a 37-bit word, MSB first.
module mtm_alu_crc3
    import mtm_alu_pkg::*;
(
    input  logic [36:0] data_i,
    output logic [2:0]  crc_o
);

    logic [2:0] crc_s;
    logic       fb_s;

    // Bit-serial Galois division unrolled over the whole message
    always_comb begin
        crc_s = 3'b000;
        fb_s  = 1'b0;
        for (int i = 36; i >= 0; i--) begin
            fb_s  = data_i[i] ^ crc_s[2];
            crc_s = {crc_s[1:0], 1'b0} ^ (fb_s ? CRC3_POLY : 3'b000);
        end
        crc_o = crc_s;
    end

endmodule

// File: rtl/mtm_alu_serializer.sv
// MTM ALU response serializer: shifts 4 data frames + 1 ctl frame (normal) or a
// single ctl frame (error) onto sout. Optional macro MTM_ALU_SER_DROP_CNT_EN
// adds a saturating count of starts that arrived while busy.
module mtm_alu_serializer
    import mtm_alu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    mtm_alu_serializer_if.slave    bus
`ifdef MTM_ALU_SER_DROP_CNT_EN
    ,
    output logic [7:0]             drop_cnt
`endif
);

    ser_state_e  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  pkt_cnt_q, pkt_cnt_d;
    logic [2:0]  last_pkt_q, last_pkt_d;
    logic [39:0] data_q, data_d;      // packet 0 in [39:32] ... packet 4 in [7:0]
    logic        sout_q, sout_d;
    logic        busy_q, busy_d;

    logic [2:0]  crc_s;
    logic [7:0]  ctl_byte_s;
    logic [7:0]  err_byte_s;
    logic [7:0]  cur_byte_s;
    logic        cur_type_s;

    // Frame bit at position idx: start, type, 8 payload bits MSB first, stop
    function automatic logic frame_bit(input logic [3:0] idx, input logic typ,
                                       input logic [7:0] pay);
        logic [3:0] k;
        k = 4'd9 - idx;
        case (idx)
            4'd0:    return START_BIT;
            4'd1:    return typ;
            4'd10:   return STOP_BIT;
            default: return (idx > 4'd10) ? STOP_BIT : pay[k[2:0]];
        endcase
    endfunction

    mtm_alu_crc3 u_crc (
        .data_i ({bus.C, 1'b0, bus.flags}),
        .crc_o  (crc_s)
    );

    assign ctl_byte_s = {1'b0, bus.flags, crc_s};
    assign err_byte_s = {1'b1, bus.err_flags, parity7({1'b1, bus.err_flags})};
    // The last packet of every response is the ctl packet
    assign cur_type_s = (pkt_cnt_q == last_pkt_q) ? TYPE_CTL : TYPE_DATA;

    // Select the payload byte of the packet currently on the wire
    always_comb begin
        case (pkt_cnt_q)
            3'd0:    cur_byte_s = data_q[39:32];
            3'd1:    cur_byte_s = data_q[31:24];
            3'd2:    cur_byte_s = data_q[23:16];
            3'd3:    cur_byte_s = data_q[15:8];
            3'd4:    cur_byte_s = data_q[7:0];
            default: cur_byte_s = 8'hFF;
        endcase
    end

    // Next-state, counters and next output bit
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        last_pkt_d = last_pkt_q;
        data_d     = data_q;
        sout_d     = sout_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                sout_d    = STOP_BIT;
                busy_d    = 1'b0;
                bit_cnt_d = 4'd0;
                pkt_cnt_d = 3'd0;
                if (bus.start && !busy_q) begin
                    state_d = SEND;
                    sout_d  = START_BIT;
                    busy_d  = 1'b1;
                    if (bus.err) begin
                        data_d     = {err_byte_s, 32'h0000_0000};
                        last_pkt_d = 3'd0;
                    end else begin
                        data_d     = {bus.C, ctl_byte_s};
                        last_pkt_d = 3'(DATA_PKTS);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (bit_cnt_q == 4'(PKT_BITS - 1)) begin
                    bit_cnt_d = 4'd0;
                    if (pkt_cnt_q == last_pkt_q) begin
                        state_d   = IDLE;
                        pkt_cnt_d = 3'd0;
                        sout_d    = STOP_BIT;
                        busy_d    = 1'b0;
                    end else begin
                        pkt_cnt_d = pkt_cnt_q + 3'd1;
                        sout_d    = START_BIT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    sout_d    = frame_bit(bit_cnt_q + 4'd1, cur_type_s, cur_byte_s);
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = 4'd0;
                pkt_cnt_d = 3'd0;
                sout_d    = STOP_BIT;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            pkt_cnt_q  <= 3'd0;
            last_pkt_q <= 3'd0;
            data_q     <= 40'h00_0000_0000;
            sout_q     <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            last_pkt_q <= last_pkt_d;
            data_q     <= data_d;
            sout_q     <= sout_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sout = sout_q;
    assign bus.busy = busy_q;

`ifdef MTM_ALU_SER_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Count starts rejected because a response is in flight, saturating
    always_comb begin
        if (bus.start && busy_q && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Self-checking bench for mtm_alu_serializer: queue-based bit-stream model,
// per-cycle compare, directed literal frames and randomized traffic.
module tb_mtm_alu_serializer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mtm_alu_serializer_if bus_if();
`ifdef MTM_ALU_SER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    mtm_alu_serializer dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if)
`ifdef MTM_ALU_SER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit   q[$];
    logic exp_sout = 1'b1;
    logic exp_busy = 1'b0;
    int   exp_drop = 0;

    // Remainder of msg * x^3 divided by x^3+x+1 (polynomial long division)
    function automatic logic [2:0] crc_model(input logic [36:0] m);
        logic [39:0] r;
        r = {m, 3'b000};
        for (int i = 39; i >= 3; i--) begin
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        end
        return r[2:0];
    endfunction

    function automatic void push_frame(input logic t, input logic [7:0] b);
        q.push_back(1'b0);
        q.push_back(t);
        for (int i = 7; i >= 0; i--) q.push_back(b[i]);
        q.push_back(1'b1);
    endfunction

    // One step per clock: accept/drop start, then present the next queued bit
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            exp_sout = 1'b1;
            exp_busy = 1'b0;
            exp_drop = 0;
        end else begin
            if (bus_if.start && exp_busy) begin
                if (exp_drop < 255) exp_drop++;
            end else if (bus_if.start) begin
                if (bus_if.err) begin
                    push_frame(1'b1, {1'b1, bus_if.err_flags, ^{1'b1, bus_if.err_flags}});
                end else begin
                    for (int k = 0; k < 4; k++) push_frame(1'b0, bus_if.C[31 - 8*k -: 8]);
                    push_frame(1'b1, {1'b0, bus_if.flags,
                                      crc_model({bus_if.C, 1'b0, bus_if.flags})});
                end
            end
            if (q.size() > 0) begin
                exp_sout = q.pop_front();
                exp_busy = 1'b1;
            end else begin
                exp_sout = 1'b1;
                exp_busy = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("sout", 64'(bus_if.sout), 64'(exp_sout));
        chk("busy", 64'(bus_if.busy), 64'(exp_busy));
`ifdef MTM_ALU_SER_DROP_CNT_EN
        chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
`endif
    end

    // ---------------- directed helpers ----------------
    logic [0:55] sv;
    logic [0:55] bz;

    task automatic run_resp(input logic [31:0] c, input logic [3:0] f, input logic e,
                            input logic [5:0] ef, input int pa, input int pb, input int rst_at);
        bus_if.C         = c;
        bus_if.flags     = f;
        bus_if.err       = e;
        bus_if.err_flags = ef;
        bus_if.start     = 1'b1;
        @(negedge clk);
        bus_if.start     = 1'b0;
        bus_if.C         = $urandom;
        bus_if.flags     = 4'($urandom_range(0, 15));
        bus_if.err       = 1'b0;
        bus_if.err_flags = 6'($urandom_range(0, 63));
        sv = '1;
        bz = '0;
        for (int i = 0; i < 56; i++) begin
            sv[i] = bus_if.sout;
            bz[i] = bus_if.busy;
            if (i == rst_at) begin
                #2 rst = 1'b0;
                #1;
                chk("rst_sout", 64'(bus_if.sout), 64'd1);
                chk("rst_busy", 64'(bus_if.busy), 64'd0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            @(negedge clk);
            bus_if.start = ((i == pa) || (i == pb)) ? 1'b1 : 1'b0;
        end
        bus_if.start = 1'b0;
    endtask

    task automatic chk_1234(input string tag);
        logic [7:0] by [4];
        by[0] = 8'h12; by[1] = 8'h34; by[2] = 8'h56; by[3] = 8'h78;
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_frame%0d", tag, k), 64'(sv[11*k +: 11]),
                64'({1'b0, 1'b0, by[k], 1'b1}));
        chk({tag, "_busy_first"}, 64'(bz[0]), 64'd1);
        chk({tag, "_busy_last"}, 64'(bz[54]), 64'd1);
        chk({tag, "_busy_fall"}, 64'(bz[55]), 64'd0);
    endtask

    int dev;
    int nb;

    initial begin
        bus_if.start     = 1'b0;
        bus_if.C         = 32'h0;
        bus_if.flags     = 4'h0;
        bus_if.err       = 1'b0;
        bus_if.err_flags = 6'h0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // idle after reset
        dev = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus_if.sout !== 1'b1 || bus_if.busy !== 1'b0) dev++;
        end
        chk("idle_deviations", 64'(dev), 64'd0);

        // data framing
        run_resp(32'h1234_5678, 4'b0000, 1'b0, 6'h00, -1, -1, -1);
        chk_1234("data");

        // CRC pin: C=0, flags=0010 -> ctl byte 0x16
        run_resp(32'h0, 4'b0010, 1'b0, 6'h00, -1, -1, -1);
        chk("crc_data0", 64'(sv[0 +: 11]), 64'({1'b0, 1'b0, 8'h00, 1'b1}));
        chk("crc_ctl", 64'(sv[44 +: 11]), 64'({1'b0, 1'b1, 8'h16, 1'b1}));

        // error responses
        run_resp(32'hDEAD_BEEF, 4'hF, 1'b1, 6'b100100, -1, -1, -1);
        chk("err_c9", 64'(sv[0 +: 11]), 64'({1'b0, 1'b1, 8'hC9, 1'b1}));
        nb = 0;
        for (int i = 0; i < 56; i++) nb += int'(bz[i]);
        chk("err_busy_len", 64'(nb), 64'd11);
        chk("err_busy_fall", 64'(bz[11]), 64'd0);
        run_resp(32'h0, 4'h0, 1'b1, 6'b010010, -1, -1, -1);
        chk("err_a5", 64'(sv[0 +: 11]), 64'({1'b0, 1'b1, 8'hA5, 1'b1}));

        // starts while busy are ignored
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_resp(32'h1234_5678, 4'b0000, 1'b0, 6'h00, 4, 19, -1);
        chk_1234("busy_start");
`ifdef MTM_ALU_SER_DROP_CNT_EN
        chk("drop_cnt_two", 64'(drop_cnt), 64'd2);
`endif

        // reset mid-response, then a clean response
        run_resp(32'h1234_5678, 4'b0000, 1'b0, 6'h00, -1, -1, 30);
        @(negedge clk);
        run_resp(32'h1234_5678, 4'b0000, 1'b0, 6'h00, -1, -1, -1);
        chk_1234("after_rst");

        // randomized traffic, inputs changing every cycle
        repeat (20000) begin
            bus_if.start     = ($urandom_range(0, 3) == 0);
            bus_if.C         = $urandom;
            bus_if.flags     = 4'($urandom_range(0, 15));
            bus_if.err       = ($urandom_range(0, 3) == 0);
            bus_if.err_flags = 6'($urandom_range(0, 63));
            @(negedge clk);
        end
        bus_if.start = 1'b0;
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mtm_alu_serializer.md
Name: mtm_alu_serializer

Overview:
- Serializes one ALU response onto the single-wire output `sout`.
- Uses the same 11-bit frame format as the input side. Each frame is: start bit 0, type bit (0 = data, 1 = ctl), 8 payload bits sent MSB first, then stop bit 1.
- A normal response is 4 data packets carrying C (MSB byte first) followed by 1 ctl packet carrying the flags and CRC3.
- An error response is a single ctl packet carrying the error flags and a parity bit.
- Sits between the ALU core and the chip output pin, mirroring `mtm_Alu_deserializer`.

Parameters:
- `DATA_PKTS`, 4, number of data packets in a normal response.
- `PKT_BITS`, 11, bits per frame.

Ports:
- `clk`  input  1  system clock; one bit per cycle.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  request strobe; sampled only when `busy` = 0.
- `C`  input  32  ALU result.
- `flags`  input  4  {carry, overflow, zero, negative}.
- `err`  input  1  1 = send an error response.
- `err_flags`  input  6  {ERR_DATA, ERR_CRC, ERR_OP, ERR_DATA, ERR_CRC, ERR_OP}.
- `sout`  output  1  serial output; idles at 1.
- `busy`  output  1  high while a response is being shifted out.
- `drop_cnt`  output  8  present only with `MTM_ALU_SER_DROP_CNT_EN`.

Behaviour:
- Reset (async, `rst` = 0):
  - `sout` = 1, `busy` = 0, `drop_cnt` = 0.
  - Packet and bit counters clear; the FSM goes to IDLE.
  - Applies immediately, including mid-frame; no partial frame resumes after reset.
- FSM states:
  - IDLE: `sout` = 1. On `start` & !`busy`, capture all inputs and compute the ctl byte, then go to SEND next cycle.
  - SEND: shift the current 11-bit frame out, one bit per clk.
  - After bit 10 (stop) of the final packet, return to IDLE.
- Latency: `start` accepted in cycle N → start bit on `sout` in cycle N+1.
- `busy`:
  - High from N+1 through the stop-bit cycle of the last packet.
  - Low in the following cycle, when a new `start` can be accepted.
  - So there is at least 1 idle bit between responses.
- Packets are back-to-back within a response, with no idle bits between frames.
- Normal response (`err` = 0), 55 bits total:
  - Packets: C[31:24], C[23:16], C[15:8], C[7:0], each with type 0.
  - Then a ctl packet, type 1, byte {1'b0, flags[3:0], crc[2:0]}.
- CRC3:
  - Polynomial x^3+x+1, init 3'b000, no final XOR.
  - Computed over the 37 bits {C[31:0], 1'b0, flags[3:0]}, MSB first.
  - Computed combinationally at capture and registered with the frame data.
- Error response (`err` = 1), 11 bits total:
  - One ctl packet, type 1, byte {1'b1, err_flags[5:0], par}.
  - par is the even parity over {1'b1, err_flags}, i.e. the XOR of those 7 bits.
  - `C` and `flags` are ignored.
- `start` while `busy` = 1: ignored. The current response is not disturbed and inputs are not re-captured.
- Inputs need to be stable only in the capture cycle.
- Bit/packet counters: a 4-bit bit counter (0..10) and a 3-bit packet counter (0..4). Both wrap to 0 at frame end and response end.

Optional Feature:
- `MTM_ALU_SER_DROP_CNT_EN` defined:
  - Adds the `drop_cnt` output port.
  - Increments on each `start` seen while `busy` = 1; saturates at 8'hFF.
  - Cleared only by reset.
- Undefined: the port and counter are absent; dropped starts are silently ignored.

Decomposition:
- Shared package `mtm_alu_pkg` holds:
  - Frame constants: START = 0, STOP = 1, TYPE_DATA = 0, TYPE_CTL = 1, `PKT_BITS`.
  - The FSM state enum {IDLE, SEND}.
  - Error-flag bit positions.
  - The CRC3 polynomial constant.
- One natural sub-module, `mtm_alu_crc3`:
  - Combinational, 37-bit input, 3-bit output.
  - Reusable by the verification reference model.

Test Plan:
- Idle check: reset released, no `start` → `sout` = 1 and `busy` = 0 for 100 cycles.
- Data framing:
  - Stimulus: C = 0x12345678, flags = 0000, `start` in cycle N.
  - Expected: cycles N+1..N+11 carry 0,0,00010010,1; the next packets carry 0x34, 0x56, 0x78.
  - `busy` falls at N+56.
- CRC:
  - Stimulus: C = 0, flags = 4'b0010.
  - Expected: ctl packet = 0,1,00010110,1 (byte 0x16, crc = 3'b110).
- Errors:
  - `err` = 1, err_flags = 6'b100100 → single frame 0,1,11001001,1 (0xC9); `busy` high for exactly 11 cycles.
  - err_flags = 6'b010010 → byte 0xA5.
- Busy and reset:
  - `start` pulses at N+5 and N+20 during a response → output is unchanged. With the macro defined, `drop_cnt` = 2.
  - `rst` asserted at bit 30 → `sout` = 1 and `busy` = 0 immediately. A following `start` gives a clean 55-bit response.
